// File: rtl/avalon_st_pkg.sv
// Shared types and helpers for the Avalon-ST arbiter codebase.
// Contents:
//   arb_state_e - arbiter FSM state encoding
//   idx_width   - width of an index into n items, never below 1 bit
package avalon_st_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/avalon_st_arbiter_if.sv
// Bundle of the arbiter's source-side and sink-side Avalon-ST signals.
// Ports: none; the signals are grouped by modport.
//   slave  - arbiter view: takes the source beats and out_ready, drives
//            in_ready and the out_* beat
//   master - environment view: the opposite directions
interface avalon_st_arbiter_if
    import avalon_st_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 32
) ();

    localparam int CW = idx_width(NUM_INPUTS);

    logic [NUM_INPUTS-1:0]            in_valid;
    logic [NUM_INPUTS-1:0]            in_ready;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
    logic [NUM_INPUTS-1:0]            in_sop;
    logic [NUM_INPUTS-1:0]            in_eop;
    logic                             out_valid;
    logic                             out_ready;
    logic [DATA_WIDTH-1:0]            out_data;
    logic                             out_sop;
    logic                             out_eop;
    logic [CW-1:0]                    out_channel;

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop, out_channel
    );

    modport master (
        output in_valid, in_data, in_sop, in_eop, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop, out_channel
    );

endinterface

// File: rtl/avalon_st_arbiter_rr_picker.sv
// Combinational round-robin picker: selects the first requester at or after
// ptr, wrapping modulo NUM_INPUTS.
// Ports:
//   req     in  NUM_INPUTS  request vector
//   ptr     in  IW          highest-priority index for this pick
//   gnt     out NUM_INPUTS  one-hot grant, zero when nobody requests
//   gnt_idx out IW          index of the granted requester (0 when none)
//   any     out 1           at least one requester
module rr_picker
    import avalon_st_pkg::*;
#(
    parameter  int NUM_INPUTS = 4,
    localparam int IW         = idx_width(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [IW-1:0]         ptr,
    output logic [NUM_INPUTS-1:0] gnt,
    output logic [IW-1:0]         gnt_idx,
    output logic                  any
);

    logic [IW-1:0] cand;

    // Explicit modulo keeps the search correct for non-power-of-2 counts.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            cand = IW'((int'(ptr) + k) % NUM_INPUTS);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/avalon_st_arbiter.sv
// Packet-aware round-robin arbiter merging NUM_INPUTS Avalon-ST sources onto
// one registered Avalon-ST sink. Each output beat carries its source index.
// With PACKET_MODE=1 the grant is held from the first accepted beat of a
// packet until its endofpacket beat is accepted.
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   bus  slave modport of avalon_st_arbiter_if (in_* sources, out_* sink)
//
// state      | meaning
// ARB_IDLE   | round-robin search from ptr; single-beat packets keep IDLE
// ARB_LOCKED | only owner is granted until its eop beat is accepted
module avalon_st_arbiter
    import avalon_st_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter bit PACKET_MODE = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    avalon_st_arbiter_if.slave  bus
);

    localparam int IW = idx_width(NUM_INPUTS);

    if (NUM_INPUTS < 2 || NUM_INPUTS > 16) begin : g_bad_num_inputs
        $fatal(1, "avalon_st_arbiter: NUM_INPUTS=%0d outside 2..16", NUM_INPUTS);
    end

    arb_state_e             state, next_state;
    logic [IW-1:0]          ptr, next_ptr;
    logic [IW-1:0]          owner, next_owner;

    logic [NUM_INPUTS-1:0]  pk_gnt;
    logic [IW-1:0]          pk_idx;
    logic                   pk_any;

    logic [NUM_INPUTS-1:0]  grant;
    logic [IW-1:0]          g_idx;
    logic                   can_load;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  beat_data;
    logic                   beat_sop;
    logic                   beat_eop;

    function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
        return (int'(i) == NUM_INPUTS - 1) ? '0 : i + 1'b1;
    endfunction

    rr_picker #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_picker (
        .req     (bus.in_valid),
        .ptr     (ptr),
        .gnt     (pk_gnt),
        .gnt_idx (pk_idx),
        .any     (pk_any)
    );

    // While locked the owner keeps in_ready even when its valid drops, so a
    // gap in the packet simply stalls the link rather than releasing it.
    always_comb begin
        grant = '0;
        g_idx = pk_idx;
        if (state == ARB_IDLE) begin
            if (pk_any) begin
                grant = pk_gnt;
            end
        end else begin
            grant[owner] = 1'b1;
            g_idx        = owner;
        end
    end

    assign can_load     = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = (can_load && !rst) ? grant : '0;
    assign accept       = |(bus.in_valid & bus.in_ready);
    assign beat_data    = bus.in_data[g_idx*DATA_WIDTH +: DATA_WIDTH];
    assign beat_sop     = bus.in_sop[g_idx];
    assign beat_eop     = bus.in_eop[g_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= next_state;
            ptr   <= next_ptr;
            owner <= next_owner;
        end
    end

    // sop is never consulted: the first beat taken in IDLE opens a packet.
    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        next_owner = owner;
        if (accept) begin
            case (state)
                ARB_IDLE: begin
                    if (PACKET_MODE && !beat_eop) begin
                        next_state = ARB_LOCKED;
                        next_owner = g_idx;
                    end else begin
                        next_ptr = inc_idx(g_idx);
                    end
                end
                ARB_LOCKED: begin
                    if (beat_eop) begin
                        next_state = ARB_IDLE;
                        next_ptr   = inc_idx(owner);
                    end
                end
                default: next_state = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid   <= 1'b0;
            bus.out_data    <= '0;
            bus.out_sop     <= 1'b0;
            bus.out_eop     <= 1'b0;
            bus.out_channel <= '0;
        end else if (can_load) begin
            bus.out_valid <= accept;
            if (accept) begin
                bus.out_data    <= beat_data;
                bus.out_sop     <= beat_sop;
                bus.out_eop     <= beat_eop;
                bus.out_channel <= g_idx;
            end
        end
    end

endmodule

// File: tb/tb_avalon_st_arbiter.sv
// Scoreboard bench for avalon_st_arbiter (NUM_INPUTS=4, DATA_WIDTH=32,
// PACKET_MODE=1). Tests queue hand-computed expected beats; a monitor pops
// and compares every beat the DUT hands over.
module tb_avalon_st_arbiter;
    import avalon_st_pkg::*;

    localparam int NI = 4;
    localparam int DW = 32;
    localparam int CW = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
        logic [CW-1:0] ch;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    beat_t src_q [NI][$];
    exp_t  exp_q [$];
    logic  gap   [NI];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    avalon_st_arbiter_if #(.NUM_INPUTS(NI), .DATA_WIDTH(DW)) bus ();

    avalon_st_arbiter #(
        .NUM_INPUTS  (NI),
        .DATA_WIDTH  (DW),
        .PACKET_MODE (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NI; i++) begin
            if (src_q[i].size() > 0 && !gap[i]) begin
                bus.in_valid[i]          = 1'b1;
                bus.in_data[i*DW +: DW]  = src_q[i][0].d;
                bus.in_sop[i]            = src_q[i][0].sop;
                bus.in_eop[i]            = src_q[i][0].eop;
            end else begin
                bus.in_valid[i]          = 1'b0;
                bus.in_data[i*DW +: DW]  = '0;
                bus.in_sop[i]            = 1'b0;
                bus.in_eop[i]            = 1'b0;
            end
        end
    endtask

    task automatic src_push(input int i, input logic [DW-1:0] d, input logic sop, input logic eop);
        beat_t b;
        b.d = d; b.sop = sop; b.eop = eop;
        src_q[i].push_back(b);
    endtask

    task automatic exp_push(input logic [DW-1:0] d, input logic sop, input logic eop, input int ch);
        exp_t e;
        e.d = d; e.sop = sop; e.eop = eop; e.ch = CW'(ch);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            src_q[i].delete();
            gap[i] = 1'b0;
        end
        drive_inputs();
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        @(posedge clk); #2;
    endtask

    // Input driver: retire accepted heads, present the next ones.
    initial begin
        forever begin
            logic [NI-1:0] acc;
            @(negedge clk);
            acc = bus.in_valid & bus.in_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
            drive_inputs();
        end
    end

    // Output monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected actual data=0x%0h ch=%0d required=no beat",
                             bus.out_data, bus.out_channel);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data",    64'(bus.out_data),    64'(e.d));
                    check("out_sop",     64'(bus.out_sop),     64'(e.sop));
                    check("out_eop",     64'(bus.out_eop),     64'(e.eop));
                    check("out_channel", 64'(bus.out_channel), 64'(e.ch));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int run;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NI; i++) gap[i] = 1'b0;
        drive_inputs();

        // Reset: outputs cleared, no ready even with a valid source.
        src_push(1, 32'hE1, 1'b1, 1'b1);
        exp_push(32'hE1, 1'b1, 1'b1, 1);
        drive_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid",   64'(bus.out_valid),   64'd0);
        check("rst_out_data",    64'(bus.out_data),    64'd0);
        check("rst_out_sop_eop", 64'({bus.out_sop, bus.out_eop}), 64'd0);
        check("rst_out_channel", 64'(bus.out_channel), 64'd0);
        check("rst_in_ready",    64'(bus.in_ready),    64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        wait_drain("drain_reset_beat");

        // Single source 2, 3-beat packet; ptr is 2 after the E1 beat.
        src_push(2, 32'hA0, 1'b1, 1'b0);
        src_push(2, 32'hA1, 1'b0, 1'b0);
        src_push(2, 32'hA2, 1'b0, 1'b1);
        exp_push(32'hA0, 1'b1, 1'b0, 2);
        exp_push(32'hA1, 1'b0, 1'b0, 2);
        exp_push(32'hA2, 1'b0, 1'b1, 2);
        drive_inputs();
        @(negedge clk);
        check("single_in_ready0", 64'(bus.in_ready), 64'b0100);
        check("single_lat_valid0", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("single_lat_valid1", 64'(bus.out_valid), 64'd1);
        check("single_lat_data1",  64'(bus.out_data),  64'hA0);
        wait_drain("drain_single");

        // ptr must now be 3: source 3 wins over source 0, then wrap to 0.
        src_push(0, 32'hB0, 1'b1, 1'b1);
        src_push(3, 32'hB3, 1'b1, 1'b1);
        exp_push(32'hB3, 1'b1, 1'b1, 3);
        exp_push(32'hB0, 1'b1, 1'b1, 0);
        drive_inputs();
        wait_drain("drain_ptr_wrap");

        // Contention from reset: packets must not interleave.
        do_reset();
        src_push(0, 32'hC0, 1'b1, 1'b0);
        src_push(0, 32'hC1, 1'b0, 1'b1);
        src_push(1, 32'hD0, 1'b1, 1'b0);
        src_push(1, 32'hD1, 1'b0, 1'b1);
        exp_push(32'hC0, 1'b1, 1'b0, 0);
        exp_push(32'hC1, 1'b0, 1'b1, 0);
        exp_push(32'hD0, 1'b1, 1'b0, 1);
        exp_push(32'hD1, 1'b0, 1'b1, 1);
        drive_inputs();
        @(negedge clk);
        check("cont_ready_c0", 64'(bus.in_ready), 64'b0001);
        @(negedge clk);
        check("cont_ready_c1", 64'(bus.in_ready), 64'b0001);
        @(negedge clk);
        check("cont_ready_d0", 64'(bus.in_ready), 64'b0010);
        wait_drain("drain_contention");

        // Fairness: all sources stream single-beat packets.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NI; i++) begin
                src_push(i, 32'h3000 + 32'(i*16 + k), 1'b1, 1'b1);
                exp_push(32'h3000 + 32'(i*16 + k), 1'b1, 1'b1, i);
            end
        end
        drive_inputs();
        run = 0;
        while (bus.out_valid !== 1'b1 && run < 20) begin
            @(negedge clk);
            run++;
        end
        run = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.out_valid === 1'b1) run++;
            @(negedge clk);
        end
        check("fair_throughput", 64'(run), 64'd12);
        wait_drain("drain_fairness");

        // Backpressure mid-packet on source 2 (ptr is 0).
        for (int k = 0; k < 6; k++) begin
            src_push(2, 32'hC0 + 32'(k), k == 0, k == 5);
            exp_push(32'hC0 + 32'(k), k == 0, k == 5, 2);
        end
        drive_inputs();
        repeat (3) @(posedge clk);
        #2;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_out_data",  64'(bus.out_data),  64'hC2);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready",  64'(bus.in_ready),  64'd0);
        end
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_resume_ready", 64'(bus.in_ready), 64'b0100);
        wait_drain("drain_backpressure");

        // Owner gap: source 1 locked, drops valid, source 3 must wait.
        do_reset();
        src_push(1, 32'h50, 1'b1, 1'b0);
        src_push(1, 32'h51, 1'b0, 1'b0);
        src_push(1, 32'h52, 1'b0, 1'b1);
        exp_push(32'h50, 1'b1, 1'b0, 1);
        exp_push(32'h51, 1'b0, 1'b0, 1);
        exp_push(32'h52, 1'b0, 1'b1, 1);
        exp_push(32'h70, 1'b1, 1'b1, 3);
        drive_inputs();
        @(posedge clk); #2;
        gap[1] = 1'b1;
        src_push(3, 32'h70, 1'b1, 1'b1);
        drive_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("gap_src3_ready", 64'(bus.in_ready[3]), 64'd0);
        end
        @(posedge clk); #2;
        gap[1] = 1'b0;
        drive_inputs();
        @(negedge clk);
        check("gap_resume_ready", 64'(bus.in_ready), 64'b0010);
        wait_drain("drain_gap");

        // Reset mid-packet on source 1: only the first beat reaches the sink.
        for (int k = 0; k < 4; k++) src_push(1, 32'h60 + 32'(k), k == 0, k == 3);
        exp_push(32'h60, 1'b1, 1'b0, 1);
        drive_inputs();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        src_q[1].delete();
        src_push(3, 32'h73, 1'b1, 1'b1);
        src_push(2, 32'h72, 1'b1, 1'b1);
        exp_push(32'h72, 1'b1, 1'b1, 2);
        exp_push(32'h73, 1'b1, 1'b1, 3);
        drive_inputs();
        @(negedge clk);
        check("rstmid_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_out_valid",   64'(bus.out_valid),   64'd0);
        check("rstmid_out_data",    64'(bus.out_data),    64'd0);
        check("rstmid_out_channel", 64'(bus.out_channel), 64'd0);
        check("rstmid_first_grant", 64'(bus.in_ready),    64'b0100);
        wait_drain("drain_rst_mid");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avalon_st_arbiter.md
Name: avalon_st_arbiter

Overview:
- Packet-aware round-robin arbiter that shares one Avalon-ST sink between NUM_INPUTS Avalon-ST sources.
- Sits upstream of the stream samplers/buffers and merges several producers onto one link.
- The output is registered, and each beat is tagged with its source index on out_channel.
- In packet mode a grant is held from the first accepted beat of a packet until its endofpacket beat is accepted.

Parameters:
- NUM_INPUTS, 4: number of requesting streams; legal range 2..16; elaboration $fatal outside that range.
- DATA_WIDTH, 32: payload width per beat.
- PACKET_MODE, 1: 1 = hold grant for a whole packet; 0 = re-arbitrate on every beat.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  NUM_INPUTS  per-source valid.
- in_ready  out  NUM_INPUTS  per-source ready.
- in_data  in  NUM_INPUTS*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_sop  in  NUM_INPUTS  per-source startofpacket.
- in_eop  in  NUM_INPUTS  per-source endofpacket.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.
- out_data  out  DATA_WIDTH  output payload.
- out_sop  out  1  output startofpacket.
- out_eop  out  1  output endofpacket.
- out_channel  out  $clog2(NUM_INPUTS)  source index of the current out beat.

Behaviour:
- Reset, synchronous on rst=1:
  - out_valid=0; out_data, out_sop, out_eop, out_channel=0.
  - State=IDLE; rr pointer=0; owner=0.
  - in_ready=0 during the reset cycle.
  - Reset asserted mid-packet discards the packet state and any held output beat, with no flush.
- Output stage: one register.
  - can_load = !out_valid || out_ready.
  - A beat is accepted from source g when in_valid[g] && in_ready[g].
  - It appears on the out_* ports the next cycle (latency 1).
  - Full throughput when out_ready stays high.
- in_ready[i] = can_load && grant[i]. At most one grant bit is set per cycle; in_ready is combinational from out_ready, valid and state.
- FSM states: IDLE and LOCKED.
  - IDLE: grant = first i with in_valid[i]=1, searching i = ptr, ptr+1, ... modulo NUM_INPUTS.
  - IDLE: if no valid input, no grant and the state is held.
  - IDLE -> LOCKED: PACKET_MODE=1 and the accepted beat has eop=0. owner <= g.
  - IDLE stays IDLE: the accepted beat has eop=1, i.e. a single-beat packet. ptr <= (g+1) mod NUM_INPUTS.
  - LOCKED: grant = owner only, regardless of other valids.
  - LOCKED, owner in_valid low: stall. No switch, no timeout.
  - LOCKED -> IDLE: when a beat with eop=1 is accepted from owner. ptr <= (owner+1) mod NUM_INPUTS.
- PACKET_MODE=0: the FSM stays in IDLE; ptr <= (g+1) mod NUM_INPUTS on every accepted beat; sop/eop pass through untouched.
- Protocol tolerance:
  - sop=0 on the first beat in IDLE is treated as a packet start.
  - sop=1 while LOCKED is forwarded as data and does not reset the lock.
  - Valid beats from non-granted sources are never dropped; they wait with in_ready=0.
- Stall behaviour:
  - out_ready=0 while out_valid=1: the output register holds and all in_ready are 0.
  - The FSM and ptr do not change during the stall.
- Wrap-around: ptr=NUM_INPUTS-1 plus an accept from that source gives ptr=0.
- Arithmetic: ptr and owner are $clog2(NUM_INPUTS) bits. The modulo is explicit for non-power-of-2 NUM_INPUTS.

Decomposition:
- Package avalon_st_pkg:
  - arb_state_e {ARB_IDLE, ARB_LOCKED}.
  - localparam function idx_width(n) = (n>1) ? $clog2(n) : 1.
- One sub-module: rr_picker.
  - Combinational: req[NUM_INPUTS] and ptr in; gnt one-hot and gnt_idx and any out.
  - Shared with future schedulers.
- The FSM, output register and ready logic live in avalon_st_arbiter.

Test Plan:
- Single source: source 2 sends a 3-beat packet (sop on beat 0, eop on beat 2, data 0xA0..0xA2) with out_ready=1 -> out beats 0xA0..0xA2 on cycles 1..3, out_channel=2 on all three, ptr=3 afterwards.
- Contention, PACKET_MODE=1: sources 0 and 1 both valid with 2-beat packets from reset -> source 0's 2 beats go out, then source 1's, with no interleaving; in_ready[1]=0 until source 0's eop is accepted.
- Fairness: all 4 sources continuously send single-beat packets (sop=eop=1) -> out_channel sequence 0,1,2,3,0,1,... with one beat per cycle.
- Backpressure: out_ready=0 for 5 cycles mid-packet -> out_data is stable, all in_ready=0, no beat is lost or duplicated, and streaming resumes the cycle after out_ready=1.
- Owner gap: the locked owner drops valid for 3 cycles while source 3 is valid -> source 3 is not granted until the owner's eop is accepted.
- Reset mid-packet: assert rst while LOCKED on source 1 -> next cycle out_valid=0 and state IDLE; the first post-reset grant goes to the lowest-index valid source.
